// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: shares one io_register port between CPU and DMA, one registered single-beat transaction per grant
// Ports: clk_mem/reset (sync, active-high); cpu_*/dma_* request, we, addr, wdata, width in and ack, rdata out;
// io_addr/io_data_in/io_read/io_write/io_width drive io_register, io_data_out is its combinational read data.
module io_bus_arbiter #(
  parameter int DMA_BURST_MAX = 4
) (
  input  logic        clk_mem,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [23:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_width,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [23:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [1:0]  dma_width,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic [23:0] io_addr,
  output logic [31:0] io_data_in,
  input  logic [31:0] io_data_out,
  output logic        io_read,
  output logic        io_write,
  output logic [1:0]  io_width
);
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  localparam logic [3:0] BURST_MAX = 4'(DMA_BURST_MAX);
  state_t     state, state_next;
  logic       grant, dma_win, owner_dma, we;
  logic [3:0] streak;
  always_comb begin
    grant      = cpu_req | dma_req;
    dma_win    = dma_req & ~(cpu_req & (streak == BURST_MAX));
    state_next = (state == IDLE) ? (grant ? ACCESS : IDLE) : (state == ACCESS) ? ACK : IDLE;
    io_read    = (state == ACCESS) & ~we;
    io_write   = (state == ACCESS) & we;
    cpu_ack    = (state == ACK) & ~owner_dma;
    dma_ack    = (state == ACK) & owner_dma;
  end
  always_ff @(posedge clk_mem)
    if (reset) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk_mem) begin
    if (reset) begin
      owner_dma  <= 1'b0;
      we         <= 1'b0;
      streak     <= 4'd0;
      io_addr    <= 24'd0;
      io_data_in <= 32'd0;
      io_width   <= 2'd0;
      cpu_rdata  <= 32'd0;
      dma_rdata  <= 32'd0;
    end else begin
      if (state == IDLE && grant) begin
        owner_dma  <= dma_win;
        we         <= dma_win ? dma_we : cpu_we;
        io_addr    <= dma_win ? dma_addr : cpu_addr;
        io_data_in <= dma_win ? dma_wdata : cpu_wdata;
        io_width   <= dma_win ? dma_width : cpu_width;
        // streak only grows while the CPU is actually being held off
        streak     <= (dma_win & cpu_req) ? ((streak == BURST_MAX) ? BURST_MAX : streak + 4'd1) : 4'd0;
      end
      if (state == ACCESS && !we) begin
        if (owner_dma) dma_rdata <= io_data_out;
        else cpu_rdata <= io_data_out;
      end
    end
  end
endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_io_bus_arbiter;
  localparam int MAXB = 4;
  logic        clk_mem = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [23:0] cpu_addr, dma_addr;
  logic [31:0] cpu_wdata, dma_wdata;
  logic [1:0]  cpu_width, dma_width;
  logic        cpu_ack, dma_ack, io_read, io_write;
  logic [31:0] cpu_rdata, dma_rdata, io_data_in, io_data_out;
  logic [23:0] io_addr;
  logic [1:0]  io_width;
  int checks = 0;
  int errors = 0;

  io_bus_arbiter #(.DMA_BURST_MAX(MAXB)) dut (
    .clk_mem(clk_mem), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_width(cpu_width), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_width(dma_width), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .io_addr(io_addr), .io_data_in(io_data_in), .io_data_out(io_data_out),
    .io_read(io_read), .io_write(io_write), .io_width(io_width)
  );

  always #5 clk_mem = ~clk_mem;

  // stand-in io_register: width-truncating store, combinational read
  logic [31:0] mem [0:4095];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = 12'd0;
  logic [31:0] pl_data = 32'd0;
  function automatic logic [31:0] shape(input logic [31:0] d, input logic [1:0] w);
    return (w == 2'b00) ? {24'd0, d[7:0]} : (w == 2'b01) ? {16'd0, d[15:0]} : d;
  endfunction
  always @(posedge clk_mem)
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (io_write) mem[io_addr[11:0]] <= shape(io_data_in, io_width);
  assign io_data_out = mem[io_addr[11:0]];

  logic [125:0] obs;
  assign obs = {io_read, io_write, io_addr, io_data_in, io_width, cpu_ack, dma_ack, cpu_rdata, dma_rdata};

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk_mem);
    pl_en = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1; cpu_req = 1'b0; dma_req = 1'b0;
    repeat (2) @(negedge clk_mem);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; cpu_req = 1'b1; dma_req = 1'b1;
    cpu_we = 1'b1; cpu_addr = 24'h000010; cpu_wdata = 32'h11111111; cpu_width = 2'b10;
    dma_we = 1'b0; dma_addr = 24'h000020; dma_wdata = 32'h22222222; dma_width = 2'b01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_mem);
      checks++;
      if (obs !== 126'd0) begin errors++; $display("FAIL reset_hold cycle %0d outputs got %h want 0", k, obs); end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    @(negedge clk_mem);
    reset = 1'b0;
    checks++;
    if ({cpu_ack, dma_ack, io_read, io_write} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes got %b want 0000", {cpu_ack, dma_ack, io_read, io_write});
    end
  endtask

  task automatic test_cpu_read;
    do_reset;
    preload(12'h100, 32'h00810005);
    cpu_we = 1'b0; cpu_addr = 24'h000100; cpu_wdata = 32'd0; cpu_width = 2'b10; cpu_req = 1'b1;
    @(negedge clk_mem);
    checks++;
    if ({io_read, io_write, io_addr, cpu_ack} !== {1'b1, 1'b0, 24'h000100, 1'b0}) begin
      errors++; $display("FAIL cpu_read_strobe rd %b wr %b addr %h ack %b want 1 0 000100 0", io_read, io_write, io_addr, cpu_ack);
    end
    @(negedge clk_mem);
    checks++;
    if ({io_read, cpu_ack, dma_ack} !== 3'b010) begin
      errors++; $display("FAIL cpu_read_ack rd/cack/dack got %b want 010", {io_read, cpu_ack, dma_ack});
    end
    checks++;
    if (cpu_rdata !== 32'h00810005) begin errors++; $display("FAIL cpu_read_data got %h want 00810005", cpu_rdata); end
    cpu_req = 1'b0;
    @(negedge clk_mem);
    checks++;
    if (cpu_ack !== 1'b0) begin errors++; $display("FAIL cpu_ack_pulse got %b want 0", cpu_ack); end
  endtask

  task automatic test_dma_write;
    do_reset;
    dma_we = 1'b1; dma_addr = 24'h000000; dma_wdata = 32'h00001234; dma_width = 2'b01; dma_req = 1'b1;
    @(negedge clk_mem);
    checks++;
    if ({io_write, io_read, io_data_in, io_width} !== {1'b1, 1'b0, 32'h00001234, 2'b01}) begin
      errors++; $display("FAIL dma_write_strobe wr %b rd %b din %h w %b want 1 0 00001234 01", io_write, io_read, io_data_in, io_width);
    end
    @(negedge clk_mem);
    checks++;
    if ({dma_ack, cpu_ack, io_write} !== 3'b100) begin
      errors++; $display("FAIL dma_write_ack dack/cack/wr got %b want 100", {dma_ack, cpu_ack, io_write});
    end
    dma_req = 1'b0;
    checks++;
    if (mem[0] !== 32'h00001234) begin errors++; $display("FAIL dma_write_commit got %h want 00001234", mem[0]); end
    checks++;
    if (dma_rdata !== 32'd0) begin errors++; $display("FAIL dma_write_rdata got %h want 0", dma_rdata); end
  endtask

  task automatic test_simultaneous;
    int cyc_d, cyc_c;
    do_reset;
    cyc_d = -1; cyc_c = -1;
    cpu_we = 1'b0; cpu_addr = 24'h000001; cpu_width = 2'b00;
    dma_we = 1'b0; dma_addr = 24'h000002; dma_width = 2'b00;
    cpu_req = 1'b1; dma_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_mem);
      if (dma_ack && cyc_d < 0) begin cyc_d = k; dma_req = 1'b0; end
      if (cpu_ack && cyc_c < 0) begin cyc_c = k; cpu_req = 1'b0; end
    end
    checks++;
    if (cyc_d != 2) begin errors++; $display("FAIL simul_dma_ack_cycle got %0d want 2", cyc_d); end
    checks++;
    if (cyc_c != 5) begin errors++; $display("FAIL simul_cpu_ack_cycle got %0d want 5", cyc_c); end
  endtask

  task automatic test_starvation;
    logic [9:0] order;
    int n, first_c;
    do_reset;
    order = 10'd0; n = 0; first_c = -1;
    cpu_we = 1'b0; cpu_addr = 24'h000003; cpu_width = 2'b10;
    dma_we = 1'b0; dma_addr = 24'h000004; dma_width = 2'b10;
    cpu_req = 1'b1; dma_req = 1'b1;
    for (int k = 1; k <= 60 && n < 10; k++) begin
      @(negedge clk_mem);
      if (dma_ack) n++;
      if (cpu_ack) begin
        order[n] = 1'b1; n++;
        if (first_c < 0) first_c = k;
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    checks++;
    if (n != 10 || order !== 10'b1000010000) begin
      errors++; $display("FAIL starve_order got n=%0d %b want n=10 1000010000 (bit i = grant i is CPU)", n, order);
    end
    checks++;
    if (first_c != 3 * MAXB + 2) begin errors++; $display("FAIL starve_cpu_wait got %0d want %0d", first_c, 3 * MAXB + 2); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    cpu_we = 1'b1; cpu_addr = 24'h000004; cpu_wdata = 32'hCAFEBABE; cpu_width = 2'b10; cpu_req = 1'b1;
    @(negedge clk_mem);
    checks++;
    if (io_write !== 1'b1) begin errors++; $display("FAIL midreset_strobe io_write got %b want 1", io_write); end
    reset = 1'b1; cpu_req = 1'b0;
    @(negedge clk_mem);
    checks++;
    if (mem[4] !== 32'hCAFEBABE) begin errors++; $display("FAIL midreset_commit got %h want cafebabe", mem[4]); end
    checks++;
    if (obs !== 126'd0) begin errors++; $display("FAIL midreset_outputs got %h want 0", obs); end
    cpu_req = 1'b1; dma_req = 1'b1; cpu_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_mem);
      checks++;
      if (obs !== 126'd0) begin errors++; $display("FAIL midreset_hold cycle %0d got %h want 0", k, obs); end
    end
    dma_req = 1'b0; reset = 1'b0;
    @(negedge clk_mem);
    checks++;
    if ({io_read, io_addr} !== {1'b1, 24'h000004}) begin
      errors++; $display("FAIL midreset_idle rd %b addr %h want 1 000004", io_read, io_addr);
    end
    @(negedge clk_mem);
    checks++;
    if ({cpu_ack, cpu_rdata} !== {1'b1, 32'hCAFEBABE}) begin
      errors++; $display("FAIL midreset_readback ack %b data %h want 1 cafebabe", cpu_ack, cpu_rdata);
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_read_then_write;
    logic seen;
    do_reset;
    preload(12'h008, 32'h5A5A0F0F);
    seen = 1'b0;
    cpu_we = 1'b0; cpu_addr = 24'h000008; cpu_width = 2'b10; cpu_req = 1'b1;
    repeat (2) @(negedge clk_mem);
    checks++;
    if (cpu_rdata !== 32'h5A5A0F0F) begin errors++; $display("FAIL rtw_read got %h want 5a5a0f0f", cpu_rdata); end
    cpu_req = 1'b0;
    dma_we = 1'b1; dma_addr = 24'h000008; dma_wdata = 32'hDEADBEEF; dma_width = 2'b10; dma_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_mem);
      if (dma_ack) begin seen = 1'b1; dma_req = 1'b0; end
      checks++;
      if (cpu_rdata !== 32'h5A5A0F0F) begin errors++; $display("FAIL rtw_hold cycle %0d got %h want 5a5a0f0f", k, cpu_rdata); end
    end
    checks++;
    if (!seen || mem[8] !== 32'hDEADBEEF || dma_rdata !== 32'd0) begin
      errors++; $display("FAIL rtw_dma_write ack %b mem %h drdata %h want 1 deadbeef 0", seen, mem[8], dma_rdata);
    end
  endtask

  // Transaction-level reference: a grant opens a 3-cycle slot (strobe, ack, idle)
  logic [31:0] ref_mem [0:15];
  logic        exp_read, exp_write, exp_cack, exp_dack, m_who, m_we;
  logic [23:0] exp_addr;
  logic [31:0] exp_din, exp_crd, exp_drd;
  logic [1:0]  exp_width;
  int          m_left, m_streak;

  task automatic model_edge;
    logic d;
    if (m_left == 0) begin
      exp_cack = 1'b0; exp_dack = 1'b0;
      if (cpu_req || dma_req) begin
        d = dma_req && !(cpu_req && m_streak == MAXB);
        m_who = d; m_we = d ? dma_we : cpu_we;
        exp_addr = d ? dma_addr : cpu_addr;
        exp_din = d ? dma_wdata : cpu_wdata;
        exp_width = d ? dma_width : cpu_width;
        m_streak = (d && cpu_req) ? ((m_streak < MAXB) ? m_streak + 1 : MAXB) : 0;
        exp_read = !m_we; exp_write = m_we; m_left = 2;
      end
    end else if (m_left == 2) begin
      if (m_we) ref_mem[exp_addr[3:0]] = shape(exp_din, exp_width);
      else if (m_who) exp_drd = ref_mem[exp_addr[3:0]];
      else exp_crd = ref_mem[exp_addr[3:0]];
      exp_read = 1'b0; exp_write = 1'b0;
      exp_cack = !m_who; exp_dack = m_who; m_left = 1;
    end else begin
      exp_cack = 1'b0; exp_dack = 1'b0; m_left = 0;
    end
  endtask

  task automatic new_cpu;
    cpu_we = 1'($urandom); cpu_addr = {12'($urandom), 8'h00, 4'($urandom)};
    cpu_wdata = $urandom; cpu_width = 2'($urandom);
  endtask

  task automatic new_dma;
    dma_we = 1'($urandom); dma_addr = {12'($urandom), 8'h00, 4'($urandom)};
    dma_wdata = $urandom; dma_width = 2'($urandom);
  endtask

  task automatic test_random;
    logic [125:0] want;
    do_reset;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      preload(12'(i), ref_mem[i]);
    end
    {exp_read, exp_write, exp_cack, exp_dack, m_who, m_we} = 6'd0;
    exp_addr = 24'd0; exp_din = 32'd0; exp_width = 2'd0; exp_crd = 32'd0; exp_drd = 32'd0;
    m_left = 0; m_streak = 0;
    for (int k = 0; k < 900; k++) begin
      if (cpu_req && exp_cack) begin
        if ($urandom_range(0, 1) == 0) cpu_req = 1'b0; else new_cpu;
      end else if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req = 1'b1; new_cpu;
      end
      if (dma_req && exp_dack) begin
        if ($urandom_range(0, 3) == 0) dma_req = 1'b0; else new_dma;
      end else if (!dma_req && $urandom_range(0, 1) == 0) begin
        dma_req = 1'b1; new_dma;
      end
      model_edge;
      @(negedge clk_mem);
      want = {exp_read, exp_write, exp_addr, exp_din, exp_width, exp_cack, exp_dack, exp_crd, exp_drd};
      checks++;
      if (obs !== want) begin errors++; $display("FAIL random cycle %0d got %h want %h", k, obs, want); end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cpu_req = 1'b0; dma_req = 1'b0;
    cpu_we = 1'b0; cpu_addr = 24'd0; cpu_wdata = 32'd0; cpu_width = 2'd0;
    dma_we = 1'b0; dma_addr = 24'd0; dma_wdata = 32'd0; dma_width = 2'd0;
    test_reset;
    test_cpu_read;
    test_dma_write;
    test_simultaneous;
    test_starvation;
    test_reset_mid;
    test_read_then_write;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/io_bus_arbiter.md
# io_bus_arbiter

Shares the single io_register access port (addr/data_in/data_out/read/write/width) between the CPU load/store unit and the DMA engine. Each requester gets one fully registered, single-beat transaction per grant. DMA has fixed priority, with a starvation cap that guarantees the CPU a slot after a configurable number of back-to-back DMA grants. The arbiter sits between both masters and the io_register instance on clk_mem.

## Interface
- DMA_BURST_MAX, default 4: maximum consecutive DMA grants while cpu_req is pending (legal range 1..15).
- clk_mem  input  1  system memory clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- cpu_req  input  1  CPU transaction request; held high until cpu_ack.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  24  io-register byte address.
- cpu_wdata  input  32  write data, unshifted, low-aligned.
- cpu_width  input  2  00 byte, 01 halfword, 1x word.
- cpu_ack  output  1  one-cycle completion pulse.
- cpu_rdata  output  32  read data; valid with cpu_ack, held until the next CPU ack.
- dma_req, dma_we, dma_addr, dma_wdata, dma_width, dma_ack, dma_rdata: same widths and meaning as the cpu_* ports, for the DMA master.
- io_addr  output  24  to io_register addr.
- io_data_in  output  32  to io_register data_in.
- io_data_out  input  32  from io_register data_out (combinational read).
- io_read  output  1  to io_register read.
- io_write  output  1  to io_register write.
- io_width  output  2  to io_register width.

## Operation
- FSM states: IDLE, ACCESS, ACK.
- IDLE: if any req is high at the clock edge, pick the winner, latch its addr/wdata/we/width into the io_* output registers, and go to ACCESS. Otherwise stay in IDLE.
- Arbitration (evaluated in IDLE only):
  - Only one req high: that requester wins.
  - Both high: DMA wins unless dma_streak == DMA_BURST_MAX, in which case CPU wins.
- dma_streak (4-bit):
  - DMA grant with cpu_req high: +1, saturating at DMA_BURST_MAX.
  - DMA grant with cpu_req low: cleared to 0.
  - CPU grant: cleared to 0.
- ACCESS: io_read = ~we or io_write = we, for exactly this one cycle. io_addr/io_data_in/io_width hold the latched values. At the end edge:
  - Reads: io_data_out is captured into the winner's rdata register.
  - Writes: the write commits in io_register.
  - Next state is ACK.
- ACK: the winner's ack is 1 for this cycle only. io_read and io_write are 0; io_addr/io_data_in/io_width keep their last values. Next state is IDLE.
- Requester contract:
  - Drop req in the cycle after ack. A req still high in IDLE is treated as a new transaction.
  - Hold addr/we/wdata/width stable from req rise until ack.
- The loser's req is not dropped; it is arbitrated at the next IDLE.
- rdata of the non-winning master is never modified.
- Write transactions leave that master's rdata unchanged.
- No address decoding: any address is forwarded unchanged. Unmapped reads return whatever io_register drives.

## Timing
- Reset (reset high at an edge): state IDLE, dma_streak 0. io_read, io_write, cpu_ack, dma_ack are 0. io_addr, io_data_in, io_width, cpu_rdata, dma_rdata are 0.
- Latency: req sampled high at edge E0 (in IDLE). io strobe is high between E0 and E1. ack is high between E1 and E2. rdata is valid from E1.
- Throughput: one transaction per 3 cycles, regardless of requester.
- Simultaneous cpu_req and dma_req rising in the same cycle: DMA is served first (streak 0 < max). CPU is served next, provided DMA drops req after its ack.
- Continuous DMA with a waiting CPU: DMA gets exactly DMA_BURST_MAX grants, then CPU gets one, then the streak restarts from 0.
- Reset mid-transaction:
  - Asserted during ACCESS: io_write is still high at that edge, so the write commits in io_register.
  - Asserted during ACCESS or ACK: no ack is issued (or the ack is cut short). The requester must reissue.
- Reset held for several cycles: all outputs stay at their reset values; req inputs are ignored.

## Test plan
- Single CPU word read at 0x000100 (io_data_out = 0x00810005): io_read high for 1 cycle with io_addr = 0x000100. cpu_ack arrives 2 edges after the req edge. cpu_rdata = 0x00810005. dma_ack stays 0.
- DMA halfword write 0x1234 to 0x000000: io_write is high for one cycle with io_data_in = 0x00001234 and io_width = 01. dma_ack follows. io_register dispcnt reads back 0x1234.
- cpu_req and dma_req rise in the same cycle: DMA ack precedes CPU ack. The grant order and 3-cycle spacing are exact.
- DMA_BURST_MAX = 4, dma_req re-asserted continuously, cpu_req held: grant sequence D,D,D,D,C,D,D,D,D,C. The CPU waits at most 4×3 + 3 cycles.
- Reset asserted in the ACCESS cycle of a CPU write: the write is visible in io_register. No cpu_ack. All outputs are 0 the next cycle, and the state is IDLE.
- CPU read followed by a DMA write: cpu_rdata keeps its read value through the DMA transaction.
